nts_ip_parse_ctrl: RTL
======================

Name: nts_ip_parse_ctrl

Overview:
- Sequencer for the IPv4/UDP header parser.
- Accepts one received Ethernet frame at a time as a 64-bit word stream. Issues parser clear, then feeds words with the one-cycle data-before-process skew the parser requires.
- After the last word, reads back UDP data offset and UDP length via the parser opcode port, classifies the frame and emits a result descriptor with valid/ready handshake to the NTS engine.

Parameters:
- ADDR_WIDTH, 10, parser word address width; offset result width = ADDR_WIDTH+3.
- IP_OPCODE_WIDTH, 4, parser read opcode width.
- MAX_WORDS, 200, maximum processed words per frame (1600 bytes).

Ports:
- i_clk  in  1  clock
- i_areset  in  1  reset
- i_rx_valid  in  1  input word valid
- o_rx_ready  out  1  word accepted when valid & ready
- i_rx_data  in  64  frame word, big-endian
- i_rx_last  in  1  final word of frame
- i_rx_bytes  in  8  last-word byte-valid mask, meaningful with i_rx_last
- o_parser_clear  out  1  parser clear strobe
- o_parser_process  out  1  parser process strobe
- o_parser_data  out  64  parser data word
- o_parser_last_word_data_valid  out  8  parser last-word mask
- o_parser_opcode  out  IP_OPCODE_WIDTH  parser read opcode
- i_parser_read_data  in  32  parser read data, combinational from opcode
- i_parser_detect_ipv4  in  1  parser IPv4 detect
- i_parser_detect_ipv4_bad  in  1  parser IPv4 with IHL≠5
- o_result_valid  out  1  descriptor valid
- i_result_ready  in  1  descriptor consumed
- o_result_status  out  3  0 OK, 1 NOT_IPV4, 2 BAD_IHL, 3 RUNT, 4 OVERSIZE
- o_result_udp_offset  out  ADDR_WIDTH+3  byte offset of UDP payload
- o_result_udp_length  out  16  UDP length field

Behaviour:
- Reset is asynchronous, active-high on i_areset; clock is i_clk.
- Reset values: all outputs 0, state IDLE. A reset mid-frame abandons the frame; the parser is re-cleared on the next frame.
- States:
  - IDLE: o_rx_ready=0. i_rx_valid -> CLEAR.
  - CLEAR: o_parser_clear=1 for exactly one cycle; word counter := 0 -> STREAM.
  - STREAM: o_rx_ready=1. On accept, word registered into o_parser_data next cycle; o_parser_process asserted the cycle after that (data leads process by exactly one cycle). Counter increments per accept and saturates at MAX_WORDS. Words accepted while counter == MAX_WORDS: no process pulse, oversize flag set. Accept with i_rx_last -> DRAIN1.
  - DRAIN1, DRAIN2: o_rx_ready=0; deliver the pending process pulse(s).
  - READ_OFS: opcode=0; capture i_parser_read_data[ADDR_WIDTH+2:0] into offset.
  - READ_LEN: opcode=1; capture [15:0] into length.
  - RESULT: o_result_valid=1; outputs held stable until i_result_ready -> IDLE. Rule: valid never drops without ready.
- Status priority, evaluated in READ_LEN from registered detect flags: OVERSIZE > RUNT (word count <5) > NOT_IPV4 > BAD_IHL > OK.
- For any status ≠ OK, offset and length outputs are forced to 0.
- Latency: last word accepted in cycle t -> o_result_valid first high in cycle t+5.
- o_parser_last_word_data_valid = i_rx_bytes registered on the last accept, else 8'hFF.
- o_rx_ready stays low from last accept until the result is consumed. A next frame presented early waits; no loss.
- A one-word frame (first word carries i_rx_last) is legal -> RUNT.

Optional Feature:
- Macro: NTS_IP_PARSE_CTRL_STATS_EN.
- Defined: adds outputs o_stat_frames, o_stat_ok and o_stat_dropped, each 32-bit.
  - Increment on each RESULT handshake; dropped = any status ≠ OK.
  - Counters wrap modulo 2^32 and reset to 0.
- Undefined: ports and logic absent; other behaviour identical.

Decomposition:
- Package nts_ip_ctrl_pkg:
  - state encoding;
  - 3-bit status codes;
  - parser opcode constants OPCODE_GET_OFFSET_UDP_DATA=0 and OPCODE_GET_LENGTH_UDP=1.
- Sub-module nts_ip_parse_ctrl_stats holds the optional counters. The FSM stays in the top block.

Test Plan:
- 10-word IPv4/UDP frame, IHL 5, UDP length 0x004C, parser model returns offset 0x2A -> one clear pulse; 10 process pulses, each one cycle after its o_parser_data word; result status 0, offset 0x2A, length 0x004C at t+5.
- Ethertype 0x86DD frame, 8 words -> status 1, offset/length 0.
- IPv4 with IHL 6 -> status 2; 3-word frame -> status 3.
- 205-word frame with MAX_WORDS=200 -> exactly 200 process pulses, all 205 words accepted, status 4.
- i_result_ready low 7 cycles with second frame pending -> descriptor stable, o_rx_ready=0, second frame starts with a fresh clear after handshake.
- i_areset asserted during word 4 -> outputs 0 immediately; next frame parsed correctly. With STATS_EN, counters are 0 after reset, then frames=1 after that frame.

Source files
------------

// File: rtl/nts_ip_ctrl_pkg.sv
// nts_ip_ctrl_pkg: state encoding, result status codes and parser opcodes
// shared by the IPv4/UDP parse sequencer and its statistics block.
package nts_ip_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLEAR    = 3'd1;
    localparam logic [2:0] ST_STREAM   = 3'd2;
    localparam logic [2:0] ST_DRAIN1   = 3'd3;
    localparam logic [2:0] ST_DRAIN2   = 3'd4;
    localparam logic [2:0] ST_READ_OFS = 3'd5;
    localparam logic [2:0] ST_READ_LEN = 3'd6;
    localparam logic [2:0] ST_RESULT   = 3'd7;

    typedef enum logic [2:0] {
        STATUS_OK       = 3'd0,
        STATUS_NOT_IPV4 = 3'd1,
        STATUS_BAD_IHL  = 3'd2,
        STATUS_RUNT     = 3'd3,
        STATUS_OVERSIZE = 3'd4
    } status_e;

    localparam int OPCODE_GET_OFFSET_UDP_DATA = 0;
    localparam int OPCODE_GET_LENGTH_UDP      = 1;

    // Frames with fewer processed words cannot hold Ethernet + IPv4 + UDP headers.
    localparam int RUNT_WORDS = 5;

    function automatic status_e classify(input logic oversize, input logic runt,
                                         input logic not_ipv4, input logic bad_ihl);
        if (oversize)      return STATUS_OVERSIZE;
        else if (runt)     return STATUS_RUNT;
        else if (not_ipv4) return STATUS_NOT_IPV4;
        else if (bad_ihl)  return STATUS_BAD_IHL;
        else               return STATUS_OK;
    endfunction

endpackage

// File: rtl/nts_ip_parse_ctrl_stats.sv
// nts_ip_parse_ctrl_stats: frame / ok / dropped counters, stepped once per
// result handshake; only instantiated when NTS_IP_PARSE_CTRL_STATS_EN is defined.
module nts_ip_parse_ctrl_stats
    import nts_ip_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_handshake,
    input  logic [2:0]  i_status,
    output logic [31:0] o_stat_frames,
    output logic [31:0] o_stat_ok,
    output logic [31:0] o_stat_dropped
);

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_stat_frames  <= '0;
            o_stat_ok      <= '0;
            o_stat_dropped <= '0;
        end else if (i_handshake) begin
            o_stat_frames <= o_stat_frames + 32'd1;
            if (i_status == 3'(STATUS_OK)) o_stat_ok <= o_stat_ok + 32'd1;
            else                           o_stat_dropped <= o_stat_dropped + 32'd1;
        end
    end

endmodule

// File: rtl/nts_ip_parse_ctrl.sv
// nts_ip_parse_ctrl: feeds one frame into the IPv4/UDP parser, reads back the
// UDP offset/length and emits a result descriptor. Macro NTS_IP_PARSE_CTRL_STATS_EN adds counters.
module nts_ip_parse_ctrl
    import nts_ip_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH      = 10,
    parameter int IP_OPCODE_WIDTH = 4,
    parameter int MAX_WORDS       = 200
) (
    input  logic                       i_clk,
    input  logic                       i_areset,
    input  logic                       i_rx_valid,
    output logic                       o_rx_ready,
    input  logic [63:0]                i_rx_data,
    input  logic                       i_rx_last,
    input  logic [7:0]                 i_rx_bytes,
    output logic                       o_parser_clear,
    output logic                       o_parser_process,
    output logic [63:0]                o_parser_data,
    output logic [7:0]                 o_parser_last_word_data_valid,
    output logic [IP_OPCODE_WIDTH-1:0] o_parser_opcode,
    input  logic [31:0]                i_parser_read_data,
    input  logic                       i_parser_detect_ipv4,
    input  logic                       i_parser_detect_ipv4_bad,
    output logic                       o_result_valid,
    input  logic                       i_result_ready,
    output logic [2:0]                 o_result_status,
    output logic [ADDR_WIDTH+2:0]      o_result_udp_offset,
    output logic [15:0]                o_result_udp_length
`ifdef NTS_IP_PARSE_CTRL_STATS_EN
    ,
    output logic [31:0]                o_stat_frames,
    output logic [31:0]                o_stat_ok,
    output logic [31:0]                o_stat_dropped
`endif
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [CNT_W-1:0]      word_count;
    logic                  accept;
    logic                  at_max;
    logic                  process_pend;
    logic                  oversize;
    logic                  det_ipv4;
    logic                  det_ipv4_bad;
    logic [ADDR_WIDTH+2:0] udp_offset;
    status_e               status_nxt;
    logic                  unused_read_data;

    assign accept           = i_rx_valid && o_rx_ready;
    assign at_max           = (word_count == CNT_W'(MAX_WORDS));
    assign o_rx_ready       = (state == ST_STREAM);
    assign o_parser_clear   = (state == ST_CLEAR);
    assign o_result_valid   = (state == ST_RESULT);
    assign o_parser_opcode  = (state == ST_READ_LEN) ? IP_OPCODE_WIDTH'(OPCODE_GET_LENGTH_UDP)
                                                     : IP_OPCODE_WIDTH'(OPCODE_GET_OFFSET_UDP_DATA);
    assign unused_read_data = ^i_parser_read_data;
    assign status_nxt       = classify(oversize, word_count < CNT_W'(RUNT_WORDS),
                                       !det_ipv4, det_ipv4_bad);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE:     if (i_rx_valid) state_nxt = ST_CLEAR;
            ST_CLEAR:    state_nxt = ST_STREAM;
            ST_STREAM:   if (accept && i_rx_last) state_nxt = ST_DRAIN1;
            ST_DRAIN1:   state_nxt = ST_DRAIN2;
            ST_DRAIN2:   state_nxt = ST_READ_OFS;
            ST_READ_OFS: state_nxt = ST_READ_LEN;
            ST_READ_LEN: state_nxt = ST_RESULT;
            ST_RESULT:   if (i_result_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Word lands in o_parser_data one cycle after accept; its process strobe follows one cycle later.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state                         <= ST_IDLE;
            word_count                    <= '0;
            process_pend                  <= 1'b0;
            oversize                      <= 1'b0;
            det_ipv4                      <= 1'b0;
            det_ipv4_bad                  <= 1'b0;
            udp_offset                    <= '0;
            o_parser_process              <= 1'b0;
            o_parser_data                 <= '0;
            o_parser_last_word_data_valid <= '0;
            o_result_status               <= '0;
            o_result_udp_offset           <= '0;
            o_result_udp_length           <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state            <= state_nxt;
            process_pend     <= accept && !at_max;
            o_parser_process <= process_pend;

            if (state == ST_CLEAR) begin
                word_count <= '0;
                oversize   <= 1'b0;
            end else if (accept) begin
                o_parser_data                 <= i_rx_data;
                o_parser_last_word_data_valid <= i_rx_last ? i_rx_bytes : 8'hFF;
                if (at_max) oversize <= 1'b1;
                else        word_count <= word_count + 1'b1;
            end

            if (state == ST_READ_OFS) begin
                udp_offset   <= i_parser_read_data[ADDR_WIDTH+2:0];
                det_ipv4     <= i_parser_detect_ipv4;
                det_ipv4_bad <= i_parser_detect_ipv4_bad;
            end

            if (state == ST_READ_LEN) begin
                o_result_status     <= status_nxt;
                o_result_udp_offset <= (status_nxt == STATUS_OK) ? udp_offset : '0;
                o_result_udp_length <= (status_nxt == STATUS_OK) ? i_parser_read_data[15:0] : 16'd0;
            end
        end
    end

`ifdef NTS_IP_PARSE_CTRL_STATS_EN
    nts_ip_parse_ctrl_stats u_stats (
        .i_clk          (i_clk),
        .i_areset       (i_areset),
        .i_handshake    (o_result_valid && i_result_ready),
        .i_status       (o_result_status),
        .o_stat_frames  (o_stat_frames),
        .o_stat_ok      (o_stat_ok),
        .o_stat_dropped (o_stat_dropped)
    );
`endif

endmodule
